cnt_calendar: RTL and testbench

- Parametrised BCD calendar counter that advances day, month, year and weekday by one on each single-cycle day tick.
- Generalises the fixed day/month/year chain with configurable year width, a programmable reset date, full Gregorian leap handling, and a validated date-load handshake.
- The weekday is kept as an incrementing counter, not recomputed each cycle.
- Sits downstream of the time-of-day counter; its ENABLE input is driven by that counter's day carry.

---
 rtl/cnt_calendar.sv | 264 ++++++++++++++++++++++++++
 tb/tb_cnt_calendar.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cnt_calendar.sv
// rtl/cnt_calendar.sv - BCD calendar counter (day/month/year/weekday) with validated load
//
// Purpose:
//   Advances a BCD date and an incrementing weekday by one on each ENABLE tick.
//   The tick normally comes from the time-of-day counter's day carry.
//   Gregorian leap years are handled. A date load is written only if it is valid.
//   Optional macro CNT_CALENDAR_DOWN_EN adds a DIR input for counting backwards.
//
// Ports:
//   CLK        in   system clock
//   RESET      in   synchronous active-high reset, loads INIT_* values
//   ENABLE     in   one-cycle day-advance tick
//   DIR        in   (CNT_CALENDAR_DOWN_EN only) 1 = step back one day
//   LOAD       in   one-cycle load request
//   LOAD_YEAR  in   BCD year to load, 4*YEAR_DIGITS bits
//   LOAD_MONTH in   BCD month to load
//   LOAD_DAY   in   BCD day to load
//   LOAD_WDAY  in   weekday to load, 0=Sunday..6=Saturday
//   day        out  BCD day 01..31
//   month      out  BCD month 01..12
//   year       out  BCD year
//   week_day   out  weekday 0..6
//   is_leap    out  current year is a leap year (combinational)
//   CARRY_out  out  one-cycle pulse when the year wraps
//   LOAD_ACK   out  one-cycle pulse when a load is accepted
//   LOAD_ERR   out  one-cycle pulse when a load is rejected

module cnt_calendar #(
    parameter int          YEAR_DIGITS = 4,
    parameter logic [15:0] INIT_YEAR   = 16'h2000,
    parameter logic [7:0]  INIT_MONTH  = 8'h01,
    parameter logic [7:0]  INIT_DAY    = 8'h01,
    parameter logic [2:0]  INIT_WDAY   = 3'd6
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     ENABLE,
`ifdef CNT_CALENDAR_DOWN_EN
    input  logic                     DIR,
`endif
    input  logic                     LOAD,
    input  logic [4*YEAR_DIGITS-1:0] LOAD_YEAR,
    input  logic [7:0]               LOAD_MONTH,
    input  logic [7:0]               LOAD_DAY,
    input  logic [2:0]               LOAD_WDAY,
    output logic [7:0]               day,
    output logic [7:0]               month,
    output logic [4*YEAR_DIGITS-1:0] year,
    output logic [2:0]               week_day,
    output logic                     is_leap,
    output logic                     CARRY_out,
    output logic                     LOAD_ACK,
    output logic                     LOAD_ERR
);

    localparam int YW = 4 * YEAR_DIGITS;

    logic [7:0]    r_day;
    logic [7:0]    r_month;
    logic [YW-1:0] r_year;
    logic [2:0]    r_wday;
    logic          r_carry;
    logic          r_ack;
    logic          r_err;

    logic          w_cur_leap;
    logic          w_load_leap;
    logic [YW-1:0] w_year_inc;
    logic [YW-1:0] w_year_dec;
    logic          w_year_all9;
    logic          w_year_all0;
    logic          w_load_ok;
    logic [7:0]    w_adv_day;
    logic [7:0]    w_adv_month;
    logic [YW-1:0] w_adv_year;
    logic [2:0]    w_adv_wday;
    logic          w_adv_carry;

    // A two-digit BCD number is divisible by 4 when an even tens digit pairs
    // with units 0/4/8, or an odd tens digit pairs with units 2/6.
    function automatic logic f_div4(input logic tens_lsb, input logic [3:0] units);
        if (tens_lsb)
            f_div4 = (units == 4'd2) || (units == 4'd6);
        else
            f_div4 = (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
    endfunction

    function automatic logic [7:0] f_dim(input logic [7:0] m, input logic leap);
        case (m)
            8'h02:                      f_dim = leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: f_dim = 8'h30;
            default:                    f_dim = 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] f_inc8(input logic [7:0] b);
        if (b[3:0] == 4'd9)
            f_inc8 = {b[7:4] + 4'd1, 4'd0};
        else
            f_inc8 = {b[7:4], b[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] f_dec8(input logic [7:0] b);
        if (b[3:0] == 4'd0)
            f_dec8 = {b[7:4] - 4'd1, 4'd9};
        else
            f_dec8 = {b[7:4], b[3:0] - 4'd1};
    endfunction

    // Century rule only exists with four digits: a year ending in 00 is leap
    // only if its upper two digits are themselves divisible by 4.
    generate
        if (YEAR_DIGITS == 4) begin : g_leap4
            assign w_cur_leap  = f_div4(r_year[4], r_year[3:0]) &&
                                 ((r_year[7:0] != 8'h00) || f_div4(r_year[12], r_year[11:8]));
            assign w_load_leap = f_div4(LOAD_YEAR[4], LOAD_YEAR[3:0]) &&
                                 ((LOAD_YEAR[7:0] != 8'h00) || f_div4(LOAD_YEAR[12], LOAD_YEAR[11:8]));
        end else begin : g_leap2
            assign w_cur_leap  = f_div4(r_year[4], r_year[3:0]);
            assign w_load_leap = f_div4(LOAD_YEAR[4], LOAD_YEAR[3:0]);
        end
    endgenerate

    assign w_year_all9 = (r_year == {YEAR_DIGITS{4'h9}});
    assign w_year_all0 = (r_year == '0);

    // Ripple increment/decrement across all BCD year digits.
    always_comb begin : p_year_step
        logic       inc_c;
        logic       dec_b;
        logic [3:0] nib_i;
        logic [3:0] nib_d;
        inc_c      = 1'b1;
        dec_b      = 1'b1;
        w_year_inc = '0;
        w_year_dec = '0;
        for (int i = 0; i < YEAR_DIGITS; i++) begin
            nib_i = r_year[4*i +: 4];
            nib_d = r_year[4*i +: 4];
            if (inc_c) begin
                if (nib_i == 4'd9) begin
                    nib_i = 4'd0;
                end else begin
                    nib_i = nib_i + 4'd1;
                    inc_c = 1'b0;
                end
            end
            if (dec_b) begin
                if (nib_d == 4'd0) begin
                    nib_d = 4'd9;
                end else begin
                    nib_d = nib_d - 4'd1;
                    dec_b = 1'b0;
                end
            end
            w_year_inc[4*i +: 4] = nib_i;
            w_year_dec[4*i +: 4] = nib_d;
        end
    end

    always_comb begin : p_load_check
        logic nib_ok;
        nib_ok = (LOAD_MONTH[7:4] <= 4'd9) && (LOAD_MONTH[3:0] <= 4'd9) &&
                 (LOAD_DAY[7:4]   <= 4'd9) && (LOAD_DAY[3:0]   <= 4'd9);
        for (int i = 0; i < YEAR_DIGITS; i++) begin
            if (LOAD_YEAR[4*i +: 4] > 4'd9)
                nib_ok = 1'b0;
        end
        // With all nibbles legal, BCD values compare correctly as binary.
        w_load_ok = nib_ok &&
                    (LOAD_MONTH >= 8'h01) && (LOAD_MONTH <= 8'h12) &&
                    (LOAD_DAY >= 8'h01) && (LOAD_DAY <= f_dim(LOAD_MONTH, w_load_leap)) &&
                    (LOAD_WDAY <= 3'd6);
    end

    always_comb begin : p_advance
        logic [7:0] prev_m;
        w_adv_day   = r_day;
        w_adv_month = r_month;
        w_adv_year  = r_year;
        w_adv_wday  = r_wday;
        w_adv_carry = 1'b0;
        prev_m      = f_dec8(r_month);
`ifdef CNT_CALENDAR_DOWN_EN
        if (DIR) begin
            w_adv_wday = (r_wday == 3'd0) ? 3'd6 : r_wday - 3'd1;
            if (r_day == 8'h01) begin
                if (r_month == 8'h01) begin
                    w_adv_month = 8'h12;
                    w_adv_day   = 8'h31;
                    w_adv_year  = w_year_dec;
                    w_adv_carry = w_year_all0;
                end else begin
                    // Only February's length depends on the year, and the
                    // previous month is in the current year unless it is December.
                    w_adv_month = prev_m;
                    w_adv_day   = f_dim(prev_m, w_cur_leap);
                end
            end else begin
                w_adv_day = f_dec8(r_day);
            end
        end else
`endif
        begin
            w_adv_wday = (r_wday == 3'd6) ? 3'd0 : r_wday + 3'd1;
            if (r_day < f_dim(r_month, w_cur_leap)) begin
                w_adv_day = f_inc8(r_day);
            end else begin
                w_adv_day = 8'h01;
                if (r_month == 8'h12) begin
                    w_adv_month = 8'h01;
                    w_adv_year  = w_year_inc;
                    w_adv_carry = w_year_all9;
                end else begin
                    w_adv_month = f_inc8(r_month);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_day   <= INIT_DAY;
            r_month <= INIT_MONTH;
            r_year  <= INIT_YEAR[YW-1:0];
            r_wday  <= INIT_WDAY;
            r_carry <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_carry <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            if (LOAD) begin
                // A same-cycle ENABLE is dropped, whether or not the load is valid.
                if (w_load_ok) begin
                    r_day   <= LOAD_DAY;
                    r_month <= LOAD_MONTH;
                    r_year  <= LOAD_YEAR;
                    r_wday  <= LOAD_WDAY;
                    r_ack   <= 1'b1;
                end else begin
                    r_err   <= 1'b1;
                end
            end else if (ENABLE) begin
                r_day   <= w_adv_day;
                r_month <= w_adv_month;
                r_year  <= w_adv_year;
                r_wday  <= w_adv_wday;
                r_carry <= w_adv_carry;
            end
        end
    end

    assign day       = r_day;
    assign month     = r_month;
    assign year      = r_year;
    assign week_day  = r_wday;
    assign is_leap   = w_cur_leap;
    assign CARRY_out = r_carry;
    assign LOAD_ACK  = r_ack;
    assign LOAD_ERR  = r_err;

endmodule

// File: tb/tb_cnt_calendar.sv
// tb/tb_cnt_calendar.sv - self-checking bench for cnt_calendar
module tb_cnt_calendar;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        ENABLE = 1'b0;
    logic        LOAD = 1'b0;
    logic [15:0] LOAD_YEAR = '0;
    logic [7:0]  LOAD_MONTH = '0;
    logic [7:0]  LOAD_DAY = '0;
    logic [2:0]  LOAD_WDAY = '0;
    logic [7:0]  day;
    logic [7:0]  month;
    logic [15:0] year;
    logic [2:0]  week_day;
    logic        is_leap;
    logic        CARRY_out;
    logic        LOAD_ACK;
    logic        LOAD_ERR;
`ifdef CNT_CALENDAR_DOWN_EN
    logic        DIR = 1'b0;
`endif

    always #5 CLK = ~CLK;

    cnt_calendar dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ENABLE     (ENABLE),
`ifdef CNT_CALENDAR_DOWN_EN
        .DIR        (DIR),
`endif
        .LOAD       (LOAD),
        .LOAD_YEAR  (LOAD_YEAR),
        .LOAD_MONTH (LOAD_MONTH),
        .LOAD_DAY   (LOAD_DAY),
        .LOAD_WDAY  (LOAD_WDAY),
        .day        (day),
        .month      (month),
        .year       (year),
        .week_day   (week_day),
        .is_leap    (is_leap),
        .CARRY_out  (CARRY_out),
        .LOAD_ACK   (LOAD_ACK),
        .LOAD_ERR   (LOAD_ERR)
    );

    typedef struct {
        logic        rst, en, ld, dir;
        logic [15:0] ly;
        logic [7:0]  lm, lday;
        logic [2:0]  lw;
        logic        chk;
        logic [7:0]  ed, em;
        logic [15:0] ey;
        logic [2:0]  ew;
        logic        el, ec, ea, ee;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    function automatic vec_t mk(input logic rst, en, ld, dir,
                                input logic [15:0] ly, input logic [7:0] lm, lday, input logic [2:0] lw,
                                input logic [7:0] ed, em, input logic [15:0] ey, input logic [2:0] ew,
                                input logic el, ec, ea, ee);
        vec_t v;
        v.rst = rst; v.en = en; v.ld = ld; v.dir = dir;
        v.ly = ly; v.lm = lm; v.lday = lday; v.lw = lw;
        v.chk = 1'b1;
        v.ed = ed; v.em = em; v.ey = ey; v.ew = ew;
        v.el = el; v.ec = ec; v.ea = ea; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive on the falling edge, queue the expectation, compare 1ns after the rising edge.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge CLK);
        RESET = v.rst; ENABLE = v.en; LOAD = v.ld;
        LOAD_YEAR = v.ly; LOAD_MONTH = v.lm; LOAD_DAY = v.lday; LOAD_WDAY = v.lw;
`ifdef CNT_CALENDAR_DOWN_EN
        DIR = v.dir;
`endif
        exp_q.push_back(v);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        step_no++;
        if (e.chk) begin
            chk("day",       step_no, {8'h00, day},        {8'h00, e.ed});
            chk("month",     step_no, {8'h00, month},      {8'h00, e.em});
            chk("year",      step_no, year,                e.ey);
            chk("week_day",  step_no, {13'h0, week_day},   {13'h0, e.ew});
            chk("is_leap",   step_no, {15'h0, is_leap},    {15'h0, e.el});
            chk("CARRY_out", step_no, {15'h0, CARRY_out},  {15'h0, e.ec});
            chk("LOAD_ACK",  step_no, {15'h0, LOAD_ACK},   {15'h0, e.ea});
            chk("LOAD_ERR",  step_no, {15'h0, LOAD_ERR},   {15'h0, e.ee});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        //           rst en ld dir  ly       lm     ld     lw    ed     em     ey       ew   l  c  a  e
        vecs.push_back(mk(1, 0, 0, 0, 'h0000, 'h00, 'h00, 0,  'h01, 'h01, 'h2000, 6,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 'h0000, 'h00, 'h00, 0,  'h01, 'h01, 'h2000, 6,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 'h2024, 'h02, 'h28, 3,  'h28, 'h02, 'h2024, 3,  1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 'h0000, 'h00, 'h00, 0,  'h29, 'h02, 'h2024, 4,  1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 'h0000, 'h00, 'h00, 0,  'h01, 'h03, 'h2024, 5,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 'h2100, 'h02, 'h28, 0,  'h28, 'h02, 'h2100, 0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 'h0000, 'h00, 'h00, 0,  'h01, 'h03, 'h2100, 1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 'h9999, 'h12, 'h31, 5,  'h31, 'h12, 'h9999, 5,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 'h0000, 'h00, 'h00, 0,  'h01, 'h01, 'h0000, 6,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 'h0000, 'h00, 'h00, 0,  'h01, 'h01, 'h0000, 6,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 'h2023, 'h02, 'h29, 1,  'h01, 'h01, 'h0000, 6,  1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 'h2023, 'h13, 'h01, 1,  'h01, 'h01, 'h0000, 6,  1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 'h2023, 'h01, 'h1A, 1,  'h01, 'h01, 'h0000, 6,  1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 'h2030, 'h06, 'h15, 6,  'h15, 'h06, 'h2030, 6,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 'h0000, 'h00, 'h00, 0,  'h16, 'h06, 'h2030, 0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 'h2030, 'h07, 'h04, 4,  'h01, 'h01, 'h2000, 6,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 'h2024, 'h01, 'h01, 7,  'h01, 'h01, 'h2000, 6,  1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 'h2000, 'h02, 'h29, 2,  'h29, 'h02, 'h2000, 2,  1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 'h1900, 'h02, 'h29, 0,  'h29, 'h02, 'h2000, 2,  1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 'h0000, 'h00, 'h00, 0,  'h01, 'h03, 'h2000, 3,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 'h2024, 'h09, 'h30, 1,  'h30, 'h09, 'h2024, 1,  1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 'h0000, 'h00, 'h00, 0,  'h01, 'h10, 'h2024, 2,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 'h2024, 'h12, 'h19, 4,  'h19, 'h12, 'h2024, 4,  1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 'h0000, 'h00, 'h00, 0,  'h20, 'h12, 'h2024, 5,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 'h2024, 'h04, 'h30, 2,  'h30, 'h04, 'h2024, 2,  1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 'h0000, 'h00, 'h00, 0,  'h01, 'h05, 'h2024, 3,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 'h2024, 'h04, 'h31, 0,  'h01, 'h05, 'h2024, 3,  1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 'h2024, 'h05, 'h31, 5,  'h31, 'h05, 'h2024, 5,  1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 'h2024, 'h00, 'h10, 1,  'h31, 'h05, 'h2024, 5,  1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 'h0000, 'h00, 'h00, 0,  'h01, 'h06, 'h2024, 6,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 'h2100, 'h02, 'h29, 3,  'h01, 'h06, 'h2024, 6,  1, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i]);

        // A full leap year of ticks from 2023-12-31 (Sunday) lands on 2024-12-30 (Monday).
        apply(mk(0, 0, 1, 0, 'h2023, 'h12, 'h31, 0,  'h31, 'h12, 'h2023, 0,  0, 0, 1, 0));
        for (int i = 0; i < 365; i++) begin
            v = mk(0, 1, 0, 0, 'h0000, 'h00, 'h00, 0,  'h30, 'h12, 'h2024, 1,  1, 0, 0, 0);
            v.chk = (i == 364);
            apply(v);
        end

`ifdef CNT_CALENDAR_DOWN_EN
        apply(mk(0, 0, 1, 0, 'h2024, 'h03, 'h01, 5,  'h01, 'h03, 'h2024, 5,  1, 0, 1, 0));
        apply(mk(0, 1, 0, 1, 'h0000, 'h00, 'h00, 0,  'h29, 'h02, 'h2024, 4,  1, 0, 0, 0));
        apply(mk(0, 0, 1, 0, 'h0000, 'h01, 'h01, 6,  'h01, 'h01, 'h0000, 6,  1, 0, 1, 0));
        apply(mk(0, 1, 0, 1, 'h0000, 'h00, 'h00, 0,  'h31, 'h12, 'h9999, 5,  0, 1, 0, 0));
        apply(mk(0, 0, 0, 0, 'h0000, 'h00, 'h00, 0,  'h31, 'h12, 'h9999, 5,  0, 0, 0, 0));
        apply(mk(0, 1, 0, 0, 'h0000, 'h00, 'h00, 0,  'h01, 'h01, 'h0000, 6,  1, 1, 0, 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
